// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code stream monitor.
package gray_pkg;

  // Monitor FSM: IDLE until the first sample sets a reference, then TRACK.
  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } gray_mon_state_e;

  // All-ones value of a given width (the modulo -1 delta). Valid for widths 1..31.
  function automatic logic [31:0] all_ones(input int unsigned width);
    logic [31:0] val;
    val = 32'd0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) val[i] = 1'b1;
    end
    return val;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational reflected-Gray to binary decoder.
module gray_to_bin #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[N-1:i];
  end

endmodule

// File: rtl/gray_seq_monitor.sv
// Gray stream checker: registers samples, decodes them to binary and classifies
// each step against the previous accepted sample as hold, +/-1 or illegal jump.
module gray_seq_monitor
  import gray_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         gray_in_i,
  input  logic                 gray_valid_i,
  input  logic                 err_clr_i,
  output logic [N-1:0]         bin_out_o,
  output logic                 bin_valid_o,
  output logic                 step_ok_o,
  output logic                 step_hold_o,
  output logic                 step_err_o,
  output logic                 dir_up_o,
  output logic                 dir_dn_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [N-1:0] DeltaUp = N'(1);
  localparam logic [N-1:0] DeltaDn = N'(all_ones(N));

  // Stage 1: raw sample capture.
  logic [N-1:0] s1_gray_q;
  logic         s1_valid_q;

  // Stage 2: decoded binary.
  logic [N-1:0] s2_bin_d;
  logic [N-1:0] s2_bin_q;
  logic         s2_valid_q;

  // Tracking state.
  gray_mon_state_e state_q, state_d;
  logic [N-1:0]    prev_bin_q, prev_bin_d;
  logic [N-1:0]    delta;

  // Registered outputs.
  logic [N-1:0]         bin_q, bin_d;
  logic                 bin_valid_q, bin_valid_d;
  logic                 step_ok_q, step_ok_d;
  logic                 step_hold_q, step_hold_d;
  logic                 step_err_q, step_err_d;
  logic                 dir_up_q, dir_up_d;
  logic                 dir_dn_q, dir_dn_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  gray_to_bin #(
    .N(N)
  ) u_gray_to_bin (
    .gray_i(s1_gray_q),
    .bin_o (s2_bin_d)
  );

  // Pipeline stages 1 and 2; reset drops any in-flight samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_gray_q  <= '0;
      s1_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_gray_q  <= gray_in_i;
      s1_valid_q <= gray_valid_i;
      s2_bin_q   <= s2_bin_d;
      s2_valid_q <= s1_valid_q;
    end
  end

  assign delta = s2_bin_q - prev_bin_q;

  // Next-state: FSM, step classification and saturating error counter.
  always_comb begin
    state_d     = state_q;
    prev_bin_d  = prev_bin_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    step_ok_d   = 1'b0;
    step_hold_d = 1'b0;
    step_err_d  = 1'b0;
    dir_up_d    = 1'b0;
    dir_dn_d    = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (s2_valid_q) begin
      bin_valid_d = 1'b1;
      bin_d       = s2_bin_q;
      // Reference always follows the newest sample, so errors resync.
      prev_bin_d  = s2_bin_q;
      unique case (state_q)
        IDLE: begin
          state_d = TRACK;
        end
        TRACK: begin
          if (delta == '0) begin
            step_hold_d = 1'b1;
          end else if (delta == DeltaUp) begin
            step_ok_d = 1'b1;
            dir_up_d  = 1'b1;
          end else if (delta == DeltaDn) begin
            step_ok_d = 1'b1;
            dir_dn_d  = 1'b1;
          end else begin
            step_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear wins over a coincident error.
    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (step_err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      prev_bin_q  <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      step_ok_q   <= 1'b0;
      step_hold_q <= 1'b0;
      step_err_q  <= 1'b0;
      dir_up_q    <= 1'b0;
      dir_dn_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_bin_q  <= prev_bin_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      step_ok_q   <= step_ok_d;
      step_hold_q <= step_hold_d;
      step_err_q  <= step_err_d;
      dir_up_q    <= dir_up_d;
      dir_dn_q    <= dir_dn_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out_o   = bin_q;
  assign bin_valid_o = bin_valid_q;
  assign step_ok_o   = step_ok_q;
  assign step_hold_o = step_hold_q;
  assign step_err_o  = step_err_q;
  assign dir_up_o    = dir_up_q;
  assign dir_dn_o    = dir_dn_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Directed bench for gray_seq_monitor: one N=4 instance with an 8-bit error
// counter and one with a 2-bit counter, both driven by the same stimulus.
module tb_gray_seq_monitor;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] gray_in_i;
  logic       gray_valid_i;
  logic       err_clr_i;

  logic [3:0] bin_out_o, bin_out_s;
  logic       bin_valid_o, bin_valid_s;
  logic       step_ok_o, step_ok_s;
  logic       step_hold_o, step_hold_s;
  logic       step_err_o, step_err_s;
  logic       dir_up_o, dir_up_s;
  logic       dir_dn_o, dir_dn_s;
  logic [7:0] err_cnt_o;
  logic [1:0] err_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  gray_seq_monitor #(
    .N        (4),
    .ERR_CNT_W(8)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .gray_in_i   (gray_in_i),
    .gray_valid_i(gray_valid_i),
    .err_clr_i   (err_clr_i),
    .bin_out_o   (bin_out_o),
    .bin_valid_o (bin_valid_o),
    .step_ok_o   (step_ok_o),
    .step_hold_o (step_hold_o),
    .step_err_o  (step_err_o),
    .dir_up_o    (dir_up_o),
    .dir_dn_o    (dir_dn_o),
    .err_cnt_o   (err_cnt_o)
  );

  gray_seq_monitor #(
    .N        (4),
    .ERR_CNT_W(2)
  ) u_dut_sat (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .gray_in_i   (gray_in_i),
    .gray_valid_i(gray_valid_i),
    .err_clr_i   (err_clr_i),
    .bin_out_o   (bin_out_s),
    .bin_valid_o (bin_valid_s),
    .step_ok_o   (step_ok_s),
    .step_hold_o (step_hold_s),
    .step_err_o  (step_err_s),
    .dir_up_o    (dir_up_s),
    .dir_dn_o    (dir_dn_s),
    .err_cnt_o   (err_cnt_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic tick(input logic [3:0] g, input logic v, input logic clr, input logic r);
    gray_in_i    = g;
    gray_valid_i = v;
    err_clr_i    = clr;
    rst_i        = r;
    @(posedge clk_i);
    #1;
  endtask

  // One sample followed by two idle cycles: its result is on the outputs now.
  // clr is held during the cycle in which the result is being classified.
  task automatic sample(input logic [3:0] g, input logic clr);
    tick(g, 1'b1, 1'b0, 1'b0);
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    tick(4'd0, 1'b0, clr, 1'b0);
  endtask

  // flags = {ok, hold, err, up, dn}; bin only checked when valid.
  task automatic check_out(input string tag, input logic v, input logic [3:0] bin,
                           input logic [4:0] flags, input logic [7:0] c8,
                           input logic [1:0] c2);
    check_eq({tag, ".valid"}, 32'(bin_valid_o), 32'(v));
    if (v) check_eq({tag, ".bin"}, 32'(bin_out_o), 32'(bin));
    check_eq({tag, ".flags"},
             32'({step_ok_o, step_hold_o, step_err_o, dir_up_o, dir_dn_o}), 32'(flags));
    check_eq({tag, ".cnt8"}, 32'(err_cnt_o), 32'(c8));
    check_eq({tag, ".sat_valid"}, 32'(bin_valid_s), 32'(v));
    check_eq({tag, ".sat_flags"},
             32'({step_ok_s, step_hold_s, step_err_s, dir_up_s, dir_dn_s}), 32'(flags));
    check_eq({tag, ".cnt2"}, 32'(err_cnt_s), 32'(c2));
  endtask

  task automatic do_reset();
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    tick(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  localparam logic [4:0] FNone = 5'b00000;
  localparam logic [4:0] FUp   = 5'b10010;
  localparam logic [4:0] FDn   = 5'b10001;
  localparam logic [4:0] FHold = 5'b01000;
  localparam logic [4:0] FErr  = 5'b00100;

  initial begin
    gray_in_i    = '0;
    gray_valid_i = 1'b0;
    err_clr_i    = 1'b0;
    rst_i        = 1'b1;

    // Reset state.
    do_reset();
    check_out("reset", 1'b0, 4'd0, FNone, 8'd0, 2'd0);
    check_eq("reset.bin", 32'(bin_out_o), 32'd0);

    // Back-to-back count 0..3: first result two edges after first capture.
    tick(4'b0000, 1'b1, 1'b0, 1'b0);
    tick(4'b0001, 1'b1, 1'b0, 1'b0);
    tick(4'b0011, 1'b1, 1'b0, 1'b0);
    check_out("seq0", 1'b1, 4'd0, FNone, 8'd0, 2'd0);
    tick(4'b0010, 1'b1, 1'b0, 1'b0);
    check_out("seq1", 1'b1, 4'd1, FUp, 8'd0, 2'd0);
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    check_out("seq2", 1'b1, 4'd2, FUp, 8'd0, 2'd0);
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    check_out("seq3", 1'b1, 4'd3, FUp, 8'd0, 2'd0);
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    check_out("seq_end", 1'b0, 4'd0, FNone, 8'd0, 2'd0);
    check_eq("seq_end.bin_held", 32'(bin_out_o), 32'd3);

    // Wrap in both directions.
    do_reset();
    sample(4'b1000, 1'b0);
    check_out("wrap_first", 1'b1, 4'd15, FNone, 8'd0, 2'd0);
    sample(4'b0000, 1'b0);
    check_out("wrap_up", 1'b1, 4'd0, FUp, 8'd0, 2'd0);
    sample(4'b1000, 1'b0);
    check_out("wrap_dn", 1'b1, 4'd15, FDn, 8'd0, 2'd0);

    // Hold across a valid gap.
    do_reset();
    sample(4'b0011, 1'b0);
    check_out("hold_first", 1'b1, 4'd2, FNone, 8'd0, 2'd0);
    for (int i = 0; i < 3; i++) tick(4'd0, 1'b0, 1'b0, 1'b0);
    check_out("hold_gap", 1'b0, 4'd0, FNone, 8'd0, 2'd0);
    sample(4'b0011, 1'b0);
    check_out("hold", 1'b1, 4'd2, FHold, 8'd0, 2'd0);

    // Illegal jump then resync.
    do_reset();
    sample(4'b0000, 1'b0);
    check_out("jump_first", 1'b1, 4'd0, FNone, 8'd0, 2'd0);
    sample(4'b0100, 1'b0);
    check_out("jump_err", 1'b1, 4'd7, FErr, 8'd1, 2'd1);
    sample(4'b0101, 1'b0);
    check_out("resync", 1'b1, 4'd6, FDn, 8'd1, 2'd1);

    // Five more illegal jumps: 6->0->7->0->7->0; 2-bit counter saturates at 3.
    sample(4'b0000, 1'b0);
    check_out("sat1", 1'b1, 4'd0, FErr, 8'd2, 2'd2);
    sample(4'b0100, 1'b0);
    check_out("sat2", 1'b1, 4'd7, FErr, 8'd3, 2'd3);
    sample(4'b0000, 1'b0);
    check_out("sat3", 1'b1, 4'd0, FErr, 8'd4, 2'd3);
    sample(4'b0100, 1'b0);
    check_out("sat4", 1'b1, 4'd7, FErr, 8'd5, 2'd3);
    sample(4'b0000, 1'b0);
    check_out("sat5", 1'b1, 4'd0, FErr, 8'd6, 2'd3);

    // Clear coincident with an error wins; FSM keeps tracking.
    sample(4'b0100, 1'b1);
    check_out("clr_err", 1'b1, 4'd7, FErr, 8'd0, 2'd0);
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    check_out("clr_after", 1'b0, 4'd0, FNone, 8'd0, 2'd0);
    sample(4'b0100, 1'b0);
    check_out("clr_track", 1'b1, 4'd7, FHold, 8'd0, 2'd0);

    // Reset with two samples in flight discards them.
    tick(4'b0001, 1'b1, 1'b0, 1'b0);
    tick(4'b0011, 1'b1, 1'b0, 1'b0);
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    check_out("mid_rst", 1'b0, 4'd0, FNone, 8'd0, 2'd0);
    check_eq("mid_rst.bin", 32'(bin_out_o), 32'd0);
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    check_out("mid_rst_1", 1'b0, 4'd0, FNone, 8'd0, 2'd0);
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    check_out("mid_rst_2", 1'b0, 4'd0, FNone, 8'd0, 2'd0);
    sample(4'b0110, 1'b0);
    check_out("post_rst_first", 1'b1, 4'd4, FNone, 8'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
